// File: rtl/branch_resolve_pkg.sv
// Shared types and helpers for the branch resolution slice.
package bp_pkg;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred_pc;
    } bp_meta_t;

    typedef enum logic {
        RS_IDLE  = 1'b0,
        RS_FLUSH = 1'b1
    } resolve_state_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch/execute inputs and BTB/redirect/statistics outputs of branch_resolve.
interface branch_resolve_if #(
    parameter int CNT_W = 16
);
    logic              stall;
    logic              f_valid;
    logic [31:0]       f_PC;
    logic              f_hit;
    logic [31:0]       f_predicted_PC;
    logic              e_is_branch;
    logic              e_taken;
    logic [31:0]       e_target;
    logic              update;
    logic [31:0]       upd_PC;
    logic [31:0]       new_BTA;
    logic              flush;
    logic [31:0]       redirect_PC;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;

    modport slave (
        input  stall, f_valid, f_PC, f_hit, f_predicted_PC,
        input  e_is_branch, e_taken, e_target,
        output update, upd_PC, new_BTA, flush, redirect_PC,
        output branch_count, mispredict_count
    );

    modport master (
        output stall, f_valid, f_PC, f_hit, f_predicted_PC,
        output e_is_branch, e_taken, e_target,
        input  update, upd_PC, new_BTA, flush, redirect_PC,
        input  branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_meta_pipe.sv
// Carries fetch-time BTB lookup results alongside the instruction to Execute.
module branch_meta_pipe
    import bp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     stall,
    input  logic     clear,
    input  bp_meta_t fetch_meta,
    output bp_meta_t exec_meta
);

    bp_meta_t stage_q [DEPTH];

    // clear wins over stall so a squash can never be held off by a frozen pipe
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!stall) begin
            stage_q[0] <= fetch_meta;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign exec_meta = stage_q[DEPTH-1];

endmodule

// File: rtl/branch_resolve.sv
// Resolves predicted vs. actual branch outcome: BTB write, flush/redirect, stats.
//   state    | meaning
//   RS_IDLE  | normal operation, Execute-slot branches are resolved
//   RS_FLUSH | flush asserted, pipe cleared, resolutions ignored
module branch_resolve
    import bp_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    branch_resolve_if.slave bus
);

    localparam int             FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    resolve_state_t    state_q;
    resolve_state_t    state_d;
    logic [FC_W-1:0]   flush_cnt_q;

    bp_meta_t          fetch_meta;
    bp_meta_t          slot;
    logic              pipe_clear;
    logic              flush_on;

    logic [31:0]       pred_pc;
    logic [31:0]       actual_pc;
    logic              mispredict;
    logic              upd_cond;
    logic              resolve;

    logic              update_q;
    logic [31:0]       upd_pc_q;
    logic [31:0]       new_bta_q;
    logic [31:0]       redirect_q;
    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  mispredict_cnt_q;

    assign fetch_meta = '{valid:   bus.f_valid,
                          pc:      bus.f_PC,
                          hit:     bus.f_hit,
                          pred_pc: bus.f_predicted_PC};

    branch_meta_pipe #(
        .DEPTH (DEPTH)
    ) u_meta_pipe (
        .clk        (clk),
        .reset      (reset),
        .stall      (bus.stall),
        .clear      (pipe_clear),
        .fetch_meta (fetch_meta),
        .exec_meta  (slot)
    );

    always_comb begin
        pred_pc    = slot.hit ? slot.pred_pc : next_seq_pc(slot.pc);
        actual_pc  = bus.e_taken ? bus.e_target : next_seq_pc(slot.pc);
        mispredict = (pred_pc != actual_pc);
        // a not-taken hit leaves the stale entry in place: the BTB cannot invalidate
        upd_cond   = bus.e_taken && (!slot.hit || (slot.pred_pc != bus.e_target));
        resolve    = slot.valid && bus.e_is_branch && !bus.stall && (state_q == RS_IDLE);
    end

    // state register plus flush-duration down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RS_IDLE;
            flush_cnt_q <= FC_LOAD;
        end else begin
            state_q <= state_d;
            if (state_q == RS_IDLE) begin
                flush_cnt_q <= FC_LOAD;
            end else if (flush_cnt_q != '0) begin
                flush_cnt_q <= flush_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RS_IDLE:  if (resolve && mispredict) state_d = RS_FLUSH;
            RS_FLUSH: if (flush_cnt_q == '0)      state_d = RS_IDLE;
            default:  state_d = RS_IDLE;
        endcase
    end

    always_comb begin
        flush_on   = (state_q == RS_FLUSH);
        pipe_clear = flush_on;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            update_q         <= 1'b0;
            upd_pc_q         <= '0;
            new_bta_q        <= '0;
            redirect_q       <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            update_q <= resolve && upd_cond;
            if (resolve && upd_cond) begin
                upd_pc_q  <= slot.pc;
                new_bta_q <= bus.e_target;
            end
            if (resolve && mispredict) begin
                redirect_q <= actual_pc;
            end
            if (resolve && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end
            if (resolve && mispredict && (mispredict_cnt_q != '1)) begin
                mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.update           = update_q;
    assign bus.upd_PC           = upd_pc_q;
    assign bus.new_BTA          = new_bta_q;
    assign bus.flush            = flush_on;
    assign bus.redirect_PC      = redirect_q;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed scenarios plus random traffic.
module tb_branch_resolve;

    localparam int DEPTH = 2;
    localparam int FC    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        f_valid;
    logic [31:0] f_PC;
    logic        f_hit;
    logic [31:0] f_predicted_PC;
    logic        e_is_branch;
    logic        e_taken;
    logic [31:0] e_target;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    branch_resolve_if #(.CNT_W(16)) bus ();
    branch_resolve_if #(.CNT_W(2))  bus_s ();

    assign bus.stall          = stall;
    assign bus.f_valid        = f_valid;
    assign bus.f_PC           = f_PC;
    assign bus.f_hit          = f_hit;
    assign bus.f_predicted_PC = f_predicted_PC;
    assign bus.e_is_branch    = e_is_branch;
    assign bus.e_taken        = e_taken;
    assign bus.e_target       = e_target;

    assign bus_s.stall          = stall;
    assign bus_s.f_valid        = f_valid;
    assign bus_s.f_PC           = f_PC;
    assign bus_s.f_hit          = f_hit;
    assign bus_s.f_predicted_PC = f_predicted_PC;
    assign bus_s.e_is_branch    = e_is_branch;
    assign bus_s.e_taken        = e_taken;
    assign bus_s.e_target       = e_target;

    branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        valid;
        bit [31:0] pc;
        bit        hit;
        bit [31:0] pred;
    } ent_t;

    typedef struct {
        int          stamp;
        bit          upd;
        bit [31:0]   upc;
        bit [31:0]   bta;
        bit          fl;
        bit [31:0]   redir;
        int unsigned bc, mc, bcs, mcs;
    } exp_t;

    ent_t        mpipe[$];        // [0] youngest, [DEPTH-1] in Execute
    exp_t        exp_q[$];
    int          flush_left;
    int unsigned m_bc, m_mc, m_bcs, m_mcs;

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_clear_pipe();
        ent_t z;
        z = '{valid: 0, pc: 0, hit: 0, pred: 0};
        mpipe.delete();
        for (int i = 0; i < DEPTH; i++) mpipe.push_back(z);
    endtask

    task automatic model_step();
        ent_t      slot, nw;
        bit        in_flush, misp, upd;
        bit [31:0] pred, actual;
        exp_t      e;
        if (reset) begin
            model_clear_pipe();
            flush_left = 0;
            m_bc = 0; m_mc = 0; m_bcs = 0; m_mcs = 0;
            return;
        end
        in_flush = (flush_left > 0);
        slot     = mpipe[DEPTH-1];
        misp     = 0;
        if (!in_flush && slot.valid && e_is_branch && !stall) begin
            pred   = slot.hit ? slot.pred : slot.pc + 32'd4;
            actual = e_taken ? e_target : slot.pc + 32'd4;
            misp   = (pred != actual);
            upd    = e_taken && (!slot.hit || slot.pred != e_target);
            m_bc   = sat_inc(m_bc, 65535);
            m_bcs  = sat_inc(m_bcs, 3);
            if (misp) begin
                m_mc  = sat_inc(m_mc, 65535);
                m_mcs = sat_inc(m_mcs, 3);
            end
            if (upd || misp) begin
                e = '{stamp: cyc, upd: upd, upc: slot.pc, bta: e_target, fl: misp,
                      redir: actual, bc: m_bc, mc: m_mc, bcs: m_bcs, mcs: m_mcs};
                exp_q.push_back(e);
            end
        end
        if (in_flush) begin
            model_clear_pipe();
        end else if (!stall) begin
            nw = '{valid: f_valid, pc: f_PC, hit: f_hit, pred: f_predicted_PC};
            mpipe.push_front(nw);
            void'(mpipe.pop_back());
        end
        if (misp) flush_left = FC;
        else if (in_flush) flush_left--;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit rst, input bit stl, input bit fv, input logic [31:0] fpc,
                        input bit fh, input logic [31:0] fpred,
                        input bit eb, input bit et, input logic [31:0] etg);
        reset = rst; stall = stl;
        f_valid = fv; f_PC = fpc; f_hit = fh; f_predicted_PC = fpred;
        e_is_branch = eb; e_taken = et; e_target = etg;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // fetch one branch, let it reach Execute, resolve it; returns just after the result edge
    task automatic fetch_resolve(input logic [31:0] pc, input bit hit, input logic [31:0] pred,
                                 input bit taken, input logic [31:0] tgt);
        step(0, 0, 1, pc, hit, pred, 0, 0, 0);
        idle(DEPTH - 1);
        step(0, 0, 0, 0, 0, 0, 1, taken, tgt);
    endtask

    // ---------------- monitor ----------------
    bit        flush_prev = 0;
    bit        rmark = 0;
    int        flen = 0;
    bit [31:0] redir_hold = 0;

    always @(negedge clk) begin
        bit   rise;
        exp_t e;
        rise = bus.flush && !flush_prev;
        while (exp_q.size() > 0 && exp_q[0].stamp + 1 < cyc) begin
            e = exp_q.pop_front();
            chk("event_missing_cycle", 64'(cyc), 64'(e.stamp + 1));
        end
        if (bus.update || rise) begin
            chk("event_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("event_cycle", 64'(cyc), 64'(e.stamp + 1));
                chk("update", bus.update, e.upd);
                chk("flush_rise", rise, e.fl);
                if (e.upd) begin
                    chk("upd_PC", bus.upd_PC, e.upc);
                    chk("new_BTA", bus.new_BTA, e.bta);
                end
                if (e.fl) chk("redirect_PC", bus.redirect_PC, e.redir);
                chk("branch_count", bus.branch_count, e.bc);
                chk("mispredict_count", bus.mispredict_count, e.mc);
                chk("small_branch_count", bus_s.branch_count, e.bcs);
                chk("small_mispredict_count", bus_s.mispredict_count, e.mcs);
            end
        end
        if (bus.flush) begin
            if (rise) begin
                flen = 1; redir_hold = bus.redirect_PC; rmark = 0;
            end else begin
                flen++;
                chk("redirect_hold", bus.redirect_PC, redir_hold);
            end
        end
        if (reset) rmark = 1;
        if (flush_prev && !bus.flush && !rmark) chk("flush_len", 64'(flen), 64'(FC));
        flush_prev = bus.flush;
    end

    // ---------------- main sequence ----------------
    initial begin
        bit [31:0] pcs [4];
        bit [31:0] pc, tgt;
        int        r;
        pcs[0] = 32'h100; pcs[1] = 32'h180; pcs[2] = 32'h2000; pcs[3] = 32'hFFFFFFFC;
        model_clear_pipe();
        flush_left = 0;

        do_reset();
        chk("rst_update", bus.update, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_upd_PC", bus.upd_PC, 0);
        chk("rst_new_BTA", bus.new_BTA, 0);
        chk("rst_redirect", bus.redirect_PC, 0);
        chk("rst_bcnt", bus.branch_count, 0);
        chk("rst_mcnt", bus.mispredict_count, 0);

        // miss, taken
        fetch_resolve(32'h100, 0, 32'h0, 1, 32'h200);
        chk("t1_update", bus.update, 1);
        chk("t1_upd_PC", bus.upd_PC, 32'h100);
        chk("t1_new_BTA", bus.new_BTA, 32'h200);
        chk("t1_flush", bus.flush, 1);
        chk("t1_redirect", bus.redirect_PC, 32'h200);
        chk("t1_bcnt", bus.branch_count, 1);
        chk("t1_mcnt", bus.mispredict_count, 1);
        idle(1);
        chk("t1_update_pulse", bus.update, 0);
        chk("t1_flush2", bus.flush, 1);
        idle(1);
        chk("t1_flush_end", bus.flush, 0);
        idle(1);

        // hit, correct
        fetch_resolve(32'h100, 1, 32'h200, 1, 32'h200);
        chk("t2_update", bus.update, 0);
        chk("t2_flush", bus.flush, 0);
        chk("t2_bcnt", bus.branch_count, 2);
        chk("t2_mcnt", bus.mispredict_count, 1);
        idle(1);

        // hit, not taken
        fetch_resolve(32'h100, 1, 32'h200, 0, 32'h0);
        chk("t3_update", bus.update, 0);
        chk("t3_flush", bus.flush, 1);
        chk("t3_redirect", bus.redirect_PC, 32'h104);
        chk("t3_mcnt", bus.mispredict_count, 2);
        idle(FC + 1);

        // hit, wrong target
        fetch_resolve(32'h100, 1, 32'h200, 1, 32'h300);
        chk("t4_update", bus.update, 1);
        chk("t4_new_BTA", bus.new_BTA, 32'h300);
        chk("t4_flush", bus.flush, 1);
        chk("t4_redirect", bus.redirect_PC, 32'h300);
        chk("t4_small_bcnt", bus_s.branch_count, 3);
        idle(FC + 1);

        // stall hold, queued branch discarded in FLUSH, reset mid-FLUSH
        do_reset();
        step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h180, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 1, 1, 32'h500);
            chk("stall_no_update", bus.update, 0);
            chk("stall_no_flush", bus.flush, 0);
        end
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h500);
        chk("stall_release_update", bus.update, 1);
        chk("stall_release_upd_PC", bus.upd_PC, 32'h100);
        chk("stall_release_flush", bus.flush, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h600);
        chk("queued_discard_update", bus.update, 0);
        chk("queued_discard_bcnt", bus.branch_count, 1);
        chk("queued_flush_held", bus.flush, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_mid_flush", bus.flush, 0);
        idle(2);

        // saturation on the 2-bit instance and PC wrap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch_resolve(32'h100, 0, 32'h0, 1, 32'h200);
            idle(FC + 1);
        end
        chk("sat_small_bcnt", bus_s.branch_count, 3);
        chk("sat_small_mcnt", bus_s.mispredict_count, 3);
        chk("sat_big_bcnt", bus.branch_count, 5);
        chk("sat_big_mcnt", bus.mispredict_count, 5);
        fetch_resolve(32'hFFFFFFFC, 1, 32'h40, 0, 32'h0);
        chk("wrap_flush", bus.flush, 1);
        chk("wrap_redirect", bus.redirect_PC, 32'h0);
        idle(FC + 1);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            bit rst_r, stl, fv, fh, eb, et;
            bit [31:0] fpred;
            rst_r = ($urandom_range(0, 299) == 0);
            stl   = ($urandom_range(0, 4) == 0);
            fv    = ($urandom_range(0, 9) < 7);
            pc    = pcs[$urandom_range(0, 3)] + 32'($urandom_range(0, 3) * 4);
            fh    = $urandom_range(0, 1);
            fpred = ($urandom_range(0, 1) != 0) ? pc + 32'd4 : 32'($urandom_range(0, 15) * 32'h40);
            eb    = ($urandom_range(0, 9) < 6);
            et    = $urandom_range(0, 1);
            r     = $urandom_range(0, 2);
            if (r == 0)      tgt = mpipe[DEPTH-1].pc + 32'd4;
            else if (r == 1) tgt = mpipe[DEPTH-1].pred;
            else             tgt = 32'($urandom_range(0, 15) * 32'h40);
            step(rst_r, stl, fv, pc, fh, fpred, eb, et, tgt);
        end
        idle(FC + 3);
        chk("queue_drained", 64'(exp_q.size()), 0);
        chk("final_bcnt", bus.branch_count, m_bc);
        chk("final_mcnt", bus.mispredict_count, m_mc);
        chk("final_small_bcnt", bus_s.branch_count, m_bcs);
        chk("final_small_mcnt", bus_s.mispredict_count, m_mcs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolving end of the branch-prediction interface. Fetch-stage BTB lookup results are carried alongside the instruction to Execute and compared there with the actual branch outcome.
- Produces the BTB write port (update, upd_PC, new_BTA), the pipeline flush/redirect on a mispredict, and branch/mispredict statistics.
- Sits between the Execute stage and the fetch-side BTB and PC mux.

Parameters:
DEPTH, 2, pipeline stages between fetch capture and execute resolution (min 1)
FLUSH_CYCLES, 2, cycles flush stays asserted per mispredict (min 1)
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; freezes metadata pipe and suppresses resolution
f_valid  input  1  valid instruction fetched this cycle
f_PC  input  32  PC of fetched instruction
f_hit  input  1  BTB hit for f_PC
f_predicted_PC  input  32  BTB-predicted target for f_PC
e_is_branch  input  1  instruction in Execute is a branch
e_taken  input  1  actual branch direction
e_target  input  32  actual branch target
update  output  1  one-cycle BTB write strobe
upd_PC  output  32  branch PC to write into BTB
new_BTA  output  32  target to write into BTB
flush  output  1  squash younger instructions
redirect_PC  output  32  correct next PC, valid while flush=1
branch_count  output  CNT_W  resolved branches, saturating
mispredict_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset: update=0, flush=0, upd_PC=new_BTA=redirect_PC=0, both counters 0, all pipe entries invalid, FSM=IDLE.
- Metadata pipe: DEPTH entries {valid, PC, hit, predicted_PC}.
  - Each cycle with stall=0, stage 0 captures f_* (valid=f_valid) and the other entries shift one stage.
  - stall=1: all entries hold.
- Execute slot: the last entry. Resolution occurs when that entry is valid, e_is_branch=1, stall=0 and FSM=IDLE.
- Prediction and outcome (all 32-bit, wrap-around on PC+4):
  - pred = hit ? predicted_PC : PC+4
  - actual = e_taken ? e_target : PC+4
  - mispredict = (pred != actual)
- BTB update:
  - Condition: e_taken && (!hit || predicted_PC != e_target).
  - Registered: update=1 for exactly one cycle, the cycle after resolution, with upd_PC=PC and new_BTA=e_target.
  - No update on not-taken, including a hit that was not taken (the BTB has no invalidate).
- Counters: branch_count +1 per resolution; mispredict_count +1 per mispredict; both saturate at all-ones. Registered, same cycle as update.
- Recovery FSM:
  - IDLE -> FLUSH on mispredict. flush=1 from the next cycle for FLUSH_CYCLES cycles, redirect_PC=actual held constant, then -> IDLE.
  - In FLUSH, all pipe entries are invalidated every cycle regardless of stall (flush beats stall).
  - Execute-slot resolutions in FLUSH are ignored: no update, no count.
- Simultaneous events:
  - Mispredict with update condition: update and flush rise in the same cycle.
  - A correct prediction produces no flush.
  - reset mid-FLUSH: synchronous return to IDLE, flush=0 next cycle.
- Non-branch valid entries in the Execute slot: no effect.

Decomposition:
- Shared package bp_pkg:
  - PC_INCR=4
  - bp_meta_t struct {valid, pc, hit, pred_pc}
  - resolve_state_t enum {RS_IDLE, RS_FLUSH}
  - helper function next_seq_pc(pc)
- Natural sub-module: branch_meta_pipe (DEPTH-stage shift register with stall hold and flush clear).
- Comparator, FSM and counters live in branch_resolve.

Test Plan:
- Miss, taken: fetch PC=0x100, f_hit=0; two cycles later e_is_branch=1, e_taken=1, e_target=0x200.
  - Next cycle: update=1, upd_PC=0x100, new_BTA=0x200, flush=1, redirect_PC=0x200 for 2 cycles.
  - Counts: branch_count=1, mispredict_count=1.
- Hit, correct: PC=0x100, hit=1, pred=0x200; resolve taken to 0x200.
  - No update, no flush; branch_count increments, mispredict_count unchanged.
- Hit, not taken: PC=0x100, hit=1, pred=0x200; resolve e_taken=0.
  - flush=1 with redirect_PC=0x104; update stays 0.
- Hit, wrong target: PC=0x100, hit=1, pred=0x200; resolve taken to 0x300.
  - update with new_BTA=0x300, flush, redirect_PC=0x300.
- Stall then flush override: hold stall=1 for 3 cycles with a branch in the Execute slot.
  - No resolution during the stall; resolves on the first stall=0 cycle.
  - A second queued branch during FLUSH is discarded; reset asserted during FLUSH gives flush=0 next cycle.
- Saturation and wrap: CNT_W=2, 5 mispredicts → both counters read 3; PC=0xFFFFFFFC not taken with pred hit → redirect_PC=0x00000000.
